// File: rtl/regfile_sched_pkg.sv
// Shared types and default widths for the register-file port scheduler.
// Optional feature macro used by the scheduler: REGFILE_SCHED_ZERO_REG_EN.
package regfile_sched_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wbuf_entry_t;

    typedef enum logic [1:0] {
        SLOT_IDLE,
        SLOT_READ,
        SLOT_DRAIN
    } slot_e;

endpackage

// File: rtl/regfile_wbuf.sv
// In-order posted-write buffer: circular FIFO with two newest-match search
// ports that also see the entry being pushed in the same cycle.
module regfile_wbuf #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic [AW-1:0] i_push_addr,
    input  logic [DW-1:0] i_push_data,
    input  logic          i_pop,
    output logic [CW-1:0] o_count,
    output logic [AW-1:0] o_head_addr,
    output logic [DW-1:0] o_head_data,
    input  logic [AW-1:0] i_s0_addr,
    output logic          o_s0_hit,
    output logic [DW-1:0] o_s0_data,
    input  logic [AW-1:0] i_s1_addr,
    output logic          o_s1_hit,
    output logic [DW-1:0] o_s1_data
);

    logic [AW-1:0] r_addr [DEPTH];
    logic [DW-1:0] r_data [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;

    // Walk oldest to newest so the last match (newest) wins; the push entry is newest of all.
    function automatic logic [DW:0] search(input logic [AW-1:0] a);
        logic          hit;
        logic [DW-1:0] data;
        logic [PW-1:0] idx;
        hit  = 1'b0;
        data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = r_rd_ptr + PW'(i);
            if ((CW'(i) < r_count) && (r_addr[idx] == a)) begin
                hit  = 1'b1;
                data = r_data[idx];
            end
        end
        if (i_push && (i_push_addr == a)) begin
            hit  = 1'b1;
            data = i_push_data;
        end
        return {hit, data};
    endfunction

    always_comb begin
        {o_s0_hit, o_s0_data} = search(i_s0_addr);
        {o_s1_hit, o_s1_data} = search(i_s1_addr);
    end

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_addr[r_wr_ptr] <= i_push_addr;
            r_data[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            if (i_push && !i_pop)      r_count <= r_count + CW'(1);
            else if (!i_push && i_pop) r_count <= r_count - CW'(1);
        end
    end

    assign o_count     = r_count;
    assign o_head_addr = r_addr[r_rd_ptr];
    assign o_head_data = r_data[r_rd_ptr];

endmodule

// File: rtl/regfile_port_sched.sv
// Arbitrates the single register-file port between decode reads and posted writebacks.
// Define REGFILE_SCHED_ZERO_REG_EN to make register 0 read as zero and drop writes to it.
module regfile_port_sched
    import regfile_sched_pkg::*;
#(
    parameter int DATA_W     = regfile_sched_pkg::DATA_W,
    parameter int ADDR_W     = regfile_sched_pkg::ADDR_W,
    parameter int WBUF_DEPTH = 4,
    parameter int MAX_WAIT   = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_rs,
    input  logic [ADDR_W-1:0] rd_rt,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_a,
    output logic [DATA_W-1:0] rsp_b,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              rf_regwrite,
    output logic [ADDR_W-1:0] rf_rs,
    output logic [ADDR_W-1:0] rf_rt,
    output logic [ADDR_W-1:0] rf_rd,
    output logic [DATA_W-1:0] rf_writedata,
    input  logic [DATA_W-1:0] rf_a,
    input  logic [DATA_W-1:0] rf_b,
    output logic              wbuf_empty
);

    localparam int CW = $clog2(WBUF_DEPTH) + 1;
    localparam int SW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    slot_e             w_slot;
    logic [CW-1:0]     w_count;
    logic              w_full;
    logic              w_nonempty;
    logic              w_push;
    logic [ADDR_W-1:0] w_head_addr;
    logic [DATA_W-1:0] w_head_data;
    logic              w_hit_a, w_hit_b;
    logic [DATA_W-1:0] w_byp_a, w_byp_b;
    logic [SW-1:0]     w_starve_next;
    logic [DATA_W-1:0] w_val_a, w_val_b;

    logic [SW-1:0]     r_starve;
    logic [ADDR_W-1:0] r_rs_last, r_rt_last, r_rd_last;
    logic [DATA_W-1:0] r_wd_last;
    logic              r_rsp_valid;
    logic              r_hit_a, r_hit_b;
    logic [DATA_W-1:0] r_byp_a, r_byp_b;

    assign w_full     = (w_count == CW'(WBUF_DEPTH));
    assign w_nonempty = (w_count != '0);
    assign wb_ready   = !w_full;
    assign wbuf_empty = !w_nonempty;

`ifdef REGFILE_SCHED_ZERO_REG_EN
    assign w_push = wb_valid && wb_ready && (wb_addr != '0);
`else
    assign w_push = wb_valid && wb_ready;
`endif

    regfile_wbuf #(
        .DEPTH (WBUF_DEPTH),
        .AW    (ADDR_W),
        .DW    (DATA_W)
    ) u_wbuf (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_addr (wb_addr),
        .i_push_data (wb_data),
        .i_pop       (rf_regwrite),
        .o_count     (w_count),
        .o_head_addr (w_head_addr),
        .o_head_data (w_head_data),
        .i_s0_addr   (rd_rs),
        .o_s0_hit    (w_hit_a),
        .o_s0_data   (w_byp_a),
        .i_s1_addr   (rd_rt),
        .o_s1_hit    (w_hit_b),
        .o_s1_data   (w_byp_b)
    );

    // Drain wins whenever the buffer is full, decode is quiet, or reads have starved it long enough.
    always_comb begin
        w_slot        = SLOT_IDLE;
        w_starve_next = '0;
        if (w_nonempty && (w_full || !rd_valid || (r_starve == SW'(MAX_WAIT)))) begin
            w_slot = SLOT_DRAIN;
        end else if (rd_valid) begin
            w_slot = SLOT_READ;
            if (w_nonempty) begin
                w_starve_next = (r_starve == SW'(MAX_WAIT)) ? r_starve : r_starve + SW'(1);
            end
        end
    end

    assign rd_ready     = (w_slot == SLOT_READ);
    assign rf_regwrite  = (w_slot == SLOT_DRAIN);
    assign rf_rs        = rd_ready ? rd_rs : r_rs_last;
    assign rf_rt        = rd_ready ? rd_rt : r_rt_last;
    assign rf_rd        = rf_regwrite ? w_head_addr : r_rd_last;
    assign rf_writedata = rf_regwrite ? w_head_data : r_wd_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve    <= '0;
            r_rs_last   <= '0;
            r_rt_last   <= '0;
            r_rd_last   <= '0;
            r_wd_last   <= '0;
            r_rsp_valid <= 1'b0;
            r_hit_a     <= 1'b0;
            r_hit_b     <= 1'b0;
            r_byp_a     <= '0;
            r_byp_b     <= '0;
        end else begin
            r_starve    <= w_starve_next;
            r_rs_last   <= rf_rs;
            r_rt_last   <= rf_rt;
            r_rd_last   <= rf_rd;
            r_wd_last   <= rf_writedata;
            r_rsp_valid <= rd_ready;
            if (rd_ready) begin
                r_hit_a <= w_hit_a;
                r_hit_b <= w_hit_b;
                r_byp_a <= w_byp_a;
                r_byp_b <= w_byp_b;
            end
        end
    end

    assign w_val_a = r_hit_a ? r_byp_a : rf_a;
    assign w_val_b = r_hit_b ? r_byp_b : rf_b;

`ifdef REGFILE_SCHED_ZERO_REG_EN
    logic r_zero_a, r_zero_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_zero_a <= 1'b0;
            r_zero_b <= 1'b0;
        end else if (rd_ready) begin
            r_zero_a <= (rd_rs == '0);
            r_zero_b <= (rd_rt == '0);
        end
    end

    assign rsp_a = (r_rsp_valid && !r_zero_a) ? w_val_a : '0;
    assign rsp_b = (r_rsp_valid && !r_zero_b) ? w_val_b : '0;
`else
    assign rsp_a = r_rsp_valid ? w_val_a : '0;
    assign rsp_b = r_rsp_valid ? w_val_b : '0;
`endif

    assign rsp_valid = r_rsp_valid;

endmodule

// File: tb/tb_regfile_port_sched.sv
// Directed scoreboard bench for regfile_port_sched with a registered-read regfile model.
module tb_regfile_port_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd_valid = 1'b0;
    logic        rd_ready;
    logic [4:0]  rd_rs = '0, rd_rt = '0;
    logic        rsp_valid;
    logic [31:0] rsp_a, rsp_b;
    logic        wb_valid = 1'b0;
    logic        wb_ready;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        rf_regwrite;
    logic [4:0]  rf_rs, rf_rt, rf_rd;
    logic [31:0] rf_writedata;
    logic [31:0] rf_a = '0, rf_b = '0;
    logic        wbuf_empty;

    localparam logic [31:0] R1 = 32'h10654321;
    localparam logic [31:0] R2 = 32'h00100022;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_rsp [$];
    logic [36:0] exp_wr  [$];
    logic [31:0] mem [32];

    always #5 clk = ~clk;

    regfile_port_sched dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_rs        (rd_rs),
        .rd_rt        (rd_rt),
        .rsp_valid    (rsp_valid),
        .rsp_a        (rsp_a),
        .rsp_b        (rsp_b),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .rf_regwrite  (rf_regwrite),
        .rf_rs        (rf_rs),
        .rf_rt        (rf_rt),
        .rf_rd        (rf_rd),
        .rf_writedata (rf_writedata),
        .rf_a         (rf_a),
        .rf_b         (rf_b),
        .wbuf_empty   (wbuf_empty)
    );

    // Register file model: preloaded while reset is held, registered read ports.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) mem[i] <= '0;
            mem[1] <= R1;
            mem[2] <= R2;
        end else if (rf_regwrite) begin
            mem[rf_rd] <= rf_writedata;
        end
        rf_a <= mem[rf_rs];
        rf_b <= mem[rf_rt];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboards whenever the DUT presents a response or a regfile write.
    initial begin
        logic [63:0] r;
        logic [36:0] w;
        forever begin
            @(negedge clk);
            if (rsp_valid) begin
                if (exp_rsp.size() == 0) begin
                    check("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    r = exp_rsp.pop_front();
                    check("rsp_a", rsp_a, r[63:32]);
                    check("rsp_b", rsp_b, r[31:0]);
                    $display("rsp a=%h b=%h", rsp_a, rsp_b);
                end
            end
            if (rf_regwrite) begin
                if (exp_wr.size() == 0) begin
                    check("drain_unexpected", 32'd1, 32'd0);
                end else begin
                    w = exp_wr.pop_front();
                    check("drain_addr", 32'(rf_rd), 32'(w[36:32]));
                    check("drain_data", rf_writedata, w[31:0]);
                    $display("drain rd=%0d data=%h", rf_rd, rf_writedata);
                end
            end
        end
    end

    // One cycle: drive at posedge+1, check handshakes at negedge, commit at posedge.
    task automatic step(input logic rv, input logic [4:0] rs, input logic [4:0] rt,
                        input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                        input logic e_rdy, input logic e_wrdy, input logic e_we,
                        input logic [31:0] ea, input logic [31:0] eb);
        rd_valid = rv; rd_rs = rs; rd_rt = rt;
        wb_valid = wv; wb_addr = wa; wb_data = wd;
        @(negedge clk);
        check("rd_ready", 32'(rd_ready), 32'(e_rdy));
        check("wb_ready", 32'(wb_ready), 32'(e_wrdy));
        check("rf_regwrite", 32'(rf_regwrite), 32'(e_we));
        if (rv && e_rdy) exp_rsp.push_back({ea, eb});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic e_we, input logic e_wrdy);
        step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, e_wrdy, e_we, 32'd0, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_a", rsp_a, 32'd0);
        check("reset_rf_regwrite", 32'(rf_regwrite), 32'd0);
        check("reset_rd_ready", 32'(rd_ready), 32'd0);
        check("reset_wb_ready", 32'(wb_ready), 32'd1);
        check("reset_wbuf_empty", 32'(wbuf_empty), 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Plain read of preloaded registers
        step(1, 1, 2, 0, 0, 0, 1, 1, 0, R1, R2);
        idle(0, 1);

        // Same-cycle write bypass, then drain on first idle slot
        exp_wr.push_back({5'd3, 32'hDEADBEEF});
        step(1, 3, 1, 1, 3, 32'hDEADBEEF, 1, 1, 0, 32'hDEADBEEF, R1);
        idle(1, 1);
        check("empty_after_t2", 32'(wbuf_empty), 32'd1);

        // Two writes to the same register: newest wins, drains in order
        exp_wr.push_back({5'd5, 32'h11});
        exp_wr.push_back({5'd5, 32'h22});
        step(1, 1, 2, 1, 5, 32'h11, 1, 1, 0, R1, R2);
        step(1, 5, 5, 1, 5, 32'h22, 1, 1, 0, 32'h22, 32'h22);
        step(1, 5, 1, 0, 0, 0, 1, 1, 0, 32'h22, R1);
        idle(1, 1);
        idle(1, 1);
        check("empty_after_t3", 32'(wbuf_empty), 32'd1);

        // Fill the buffer under continuous reads; full forces a drain
        for (int i = 0; i < 4; i++) exp_wr.push_back({5'(6 + i), 32'(8'h60 + 8'h10 * i)});
        exp_wr.push_back({5'd10, 32'hEE});
        step(1, 1, 2, 1, 6, 32'h60, 1, 1, 0, R1, R2);
        step(1, 1, 2, 1, 7, 32'h70, 1, 1, 0, R1, R2);
        step(1, 1, 2, 1, 8, 32'h80, 1, 1, 0, R1, R2);
        step(1, 1, 2, 1, 9, 32'h90, 1, 1, 0, R1, R2);
        step(1, 1, 2, 1, 10, 32'hEE, 0, 0, 1, 32'd0, 32'd0);
        step(1, 6, 10, 1, 10, 32'hEE, 1, 1, 0, 32'h60, 32'hEE);
        idle(1, 0);
        idle(1, 1);
        idle(1, 1);
        idle(1, 1);
        check("empty_after_t4", 32'(wbuf_empty), 32'd1);

        // Starvation limit: three grants, one forced drain, reads resume
        exp_wr.push_back({5'd10, 32'hA0});
        step(0, 0, 0, 1, 10, 32'hA0, 0, 1, 0, 32'd0, 32'd0);
        step(1, 10, 1, 0, 0, 0, 1, 1, 0, 32'hA0, R1);
        step(1, 2, 10, 0, 0, 0, 1, 1, 0, R2, 32'hA0);
        step(1, 1, 1, 0, 0, 0, 1, 1, 0, R1, R1);
        step(1, 1, 1, 0, 0, 0, 0, 1, 1, 32'd0, 32'd0);
        step(1, 10, 10, 0, 0, 0, 1, 1, 0, 32'hA0, 32'hA0);
        idle(0, 1);

        // Asynchronous reset with two buffered writes and a response pending
        step(0, 0, 0, 1, 11, 32'hB1, 0, 1, 0, 32'd0, 32'd0);
        step(1, 1, 2, 1, 12, 32'hB2, 1, 1, 0, R1, R2);
        rd_valid = 1'b0;
        wb_valid = 1'b0;
        #1;
        check("pending_rsp_valid", 32'(rsp_valid), 32'd1);
        check("pending_wbuf_empty", 32'(wbuf_empty), 32'd0);
        rst_n = 1'b0;
        #1;
        check("async_rsp_valid", 32'(rsp_valid), 32'd0);
        check("async_rsp_a", rsp_a, 32'd0);
        check("async_rsp_b", rsp_b, 32'd0);
        check("async_wbuf_empty", 32'(wbuf_empty), 32'd1);
        check("async_rf_regwrite", 32'(rf_regwrite), 32'd0);
        exp_rsp.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(0, 1);
        idle(0, 1);
        idle(0, 1);
        check("empty_after_reset", 32'(wbuf_empty), 32'd1);

        check("rsp_queue_drained", 32'(exp_rsp.size()), 32'd0);
        check("wr_queue_drained", 32'(exp_wr.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_port_sched.md
Name: regfile_port_sched

Overview:
- Shares the single-port-per-cycle register file (a cycle is either one write or one rs/rt read pair) between decode (reads) and writeback (writes).
- Writes are posted into a small in-order buffer and drained in idle or forced slots.
- Reads see buffered writes through bypass, so decode observes program-order values.
- Sits between the decode and writeback stages and the register file's control inputs.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register address width
- WBUF_DEPTH, 4, posted-write buffer entries (power of 2, at least 2)
- MAX_WAIT, 3, consecutive read grants allowed while the buffer is non-empty before a drain is forced

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- rd_valid  in  1  decode read request
- rd_ready  out  1  read granted this cycle
- rd_rs  in  ADDR_W  first source register
- rd_rt  in  ADDR_W  second source register
- rsp_valid  out  1  read data valid; no backpressure
- rsp_a  out  DATA_W  rs value
- rsp_b  out  DATA_W  rt value
- wb_valid  in  1  writeback write request
- wb_ready  out  1  write accepted
- wb_addr  in  ADDR_W  destination register
- wb_data  in  DATA_W  write data
- rf_regwrite  out  1  register-file write enable
- rf_rs  out  ADDR_W  register-file read address 1
- rf_rt  out  ADDR_W  register-file read address 2
- rf_rd  out  ADDR_W  register-file write address
- rf_writedata  out  DATA_W  register-file write data
- rf_a  in  DATA_W  register-file read data 1, registered, valid the cycle after issue
- rf_b  in  DATA_W  register-file read data 2, registered, valid the cycle after issue
- wbuf_empty  out  1  buffer empty (pipeline quiesce)

Behaviour:
- Reset (asynchronous, rst_n=0): buffer count=0, pointers=0, starve count=0, pending response cleared.
  - Registered outputs rsp_valid, rsp_a, rsp_b go to 0.
  - Combinational outputs follow the reset state: rf_regwrite=0, rd_ready=0, wb_ready=1, wbuf_empty=1.
  - Buffered writes are discarded.
- Slot select (combinational, one per cycle):
  - DRAIN if count>0 and (count==WBUF_DEPTH, or !rd_valid, or starve==MAX_WAIT).
  - Otherwise READ if rd_valid.
  - Otherwise IDLE.
- DRAIN: rf_regwrite=1, rf_rd and rf_writedata taken from the buffer head; head pops at the clock edge; rd_ready=0; starve reset to 0.
- READ: rf_regwrite=0, rf_rs=rd_rs, rf_rt=rd_rt, rd_ready=1.
  - starve increments if count>0, saturating at MAX_WAIT; otherwise it stays 0.
- IDLE: rf_regwrite=0, address outputs hold their last values.
- wb_ready = (count != WBUF_DEPTH).
  - An accepted write is appended at the tail.
  - Enqueue and dequeue in the same cycle leave count unchanged.
  - Multiple entries to the same address are kept and drained in order.
- Response: rsp_valid=1 exactly one cycle after a READ grant.
  - rsp_a = bypass_a_hit ? bypass_a_data : rf_a; rsp_b likewise.
- Bypass (evaluated in the READ cycle, result registered):
  - Searched set is the buffer contents plus the same-cycle accepted wb write. The same-cycle write counts as older than the read, and newest.
  - When several entries match, the newest wins.
- Back-to-back READs give back-to-back rsp_valid.
- rd and wb arriving together with the buffer not full: READ wins unless a forced drain applies; the write is still enqueued.
- wbuf_empty = (count==0).

Optional Feature:
- Macro: REGFILE_SCHED_ZERO_REG_EN.
- Defined:
  - Writes to address 0 are accepted (wb_ready as normal) but not enqueued.
  - rsp_a or rsp_b is forced to 0 when the corresponding rs or rt is 0, regardless of rf_a, rf_b or bypass.
- Undefined: address 0 is an ordinary register.

Decomposition:
- Package regfile_sched_pkg:
  - ADDR_W and DATA_W constants.
  - wbuf_entry_t struct {addr, data}.
  - Slot enum {SLOT_IDLE, SLOT_READ, SLOT_DRAIN}.
- Sub-module regfile_wbuf:
  - Circular FIFO with count, push, pop and head outputs.
  - Two newest-match search ports (address in, hit and data out), each including the push-port entry.

Test Plan:
- Reset, regfile preloaded with R1=0x10654321 and R2=0x00100022; read rs=1, rt=2 → rf_regwrite=0 on the grant cycle; next cycle rsp_valid=1, rsp_a=0x10654321, rsp_b=0x00100022.
- wb addr=3, data=0xDEADBEEF and read rs=3, rt=1 in the same cycle → rsp_a=0xDEADBEEF (bypass), rsp_b=0x10654321; first idle cycle is DRAIN with rf_rd=3, rf_writedata=0xDEADBEEF.
- Writes addr=5 of 0x11 then 0x22, then read rs=5 → rsp_a=0x22; drains issue 0x11 then 0x22 in order; wbuf_empty=1 afterwards.
- Four writes while rd_valid is held high → wb_ready=0 at count=4; the next cycle is DRAIN with rd_ready=0; wb_ready=1 the following cycle.
- One buffered write with rd_valid held high → exactly 3 READ grants, then one DRAIN, then reads resume.
- rst_n=0 mid-run with 2 entries buffered and a response pending → outputs clear immediately; after release, no rf_regwrite=1 cycles and wbuf_empty=1.
